// File: rtl/uart_rx.sv
// UART receiver driven by a 16x-oversample tick: 2-flop line synchroniser, mid-bit sampling, LSB first.
// Optional even-parity check is built in when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_tick,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_data,
  output logic            o_rx_done,
  output logic            o_frame_err,
  output logic            o_parity_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  logic [4:0]      s_cnt;
  logic [2:0]      n_cnt;
  logic [DBIT-1:0] shreg;
  logic            sync_p0;
  logic            rx_s;
`ifdef UART_RX_PARITY_EN
  logic            par_bit;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_p0 <= i_rx;
      rx_s    <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      s_cnt       <= 5'd0;
      n_cnt       <= 3'd0;
      shreg       <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_rx_done <= 1'b0;
      case (state)
        // Start edge needs no tick, so a coincident tick is not counted
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= 5'd0;
          end
        end
        START: begin
          if (i_tick) begin
            if (s_cnt == 5'd7) begin
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= 5'd0;
                n_cnt <= 3'd0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (s_cnt == 5'd15) begin
              s_cnt <= 5'd0;
              shreg <= {rx_s, shreg[DBIT-1:1]};
              if (n_cnt == 3'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n_cnt <= n_cnt + 3'd1;
              end
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_tick) begin
            if (s_cnt == 5'd15) begin
              s_cnt   <= 5'd0;
              par_bit <= rx_s;
              state   <= STOP;
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
`endif
        // Stop is sampled mid-bit; returning to IDLE here lets back-to-back frames through
        STOP: begin
          if (i_tick) begin
            if (s_cnt == 5'(SB_TICK-1)) begin
              o_data      <= shreg;
              o_frame_err <= ~rx_s;
              o_rx_done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              o_parity_err <= ^{shreg, par_bit};
`endif
              state <= IDLE;
            end else begin
              s_cnt <= s_cnt + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

endmodule
